// File: rtl/gray_ptr_receiver_if.sv
// rtl/gray_ptr_receiver_if.sv - control, Gray input and tracking outputs of the Gray pointer receiver
interface gray_ptr_receiver_if #(
   parameter int bit_width = 8,
   parameter int acc_width = 16
);
   logic                 enable;
   logic                 clear;
   logic [bit_width-1:0] gray_in;
   logic                 locked;
   logic [bit_width-1:0] bin_out;
   logic                 step_valid;
   logic [bit_width-1:0] delta;
   logic                 multi_step;
   logic [acc_width-1:0] acc_out;
   logic                 acc_overflow;

   // Producer/observer side: drives controls and the Gray pointer
   modport master (
      output enable, clear, gray_in,
      input  locked, bin_out, step_valid, delta, multi_step, acc_out, acc_overflow
   );

   // Receiver side
   modport slave (
      input  enable, clear, gray_in,
      output locked, bin_out, step_valid, delta, multi_step, acc_out, acc_overflow
   );
endinterface

// File: rtl/gray_ptr_receiver.sv
// rtl/gray_ptr_receiver.sv - synchronises a Gray pointer, decodes it and tracks its advances
module gray_ptr_receiver #(
   parameter int bit_width   = 8,
   parameter int sync_stages = 2,
   parameter int acc_width   = 16
) (
   input  logic              clk,
   input  logic              rst,
   gray_ptr_receiver_if.slave bus
);
   localparam int CW = $clog2(sync_stages + 1);
   localparam int SW = ((acc_width > bit_width) ? acc_width : bit_width) + 1;
   localparam logic [bit_width-1:0] ONE      = 1;
   localparam logic [CW-1:0]        LAST_CNT = CW'(sync_stages - 1);

   typedef enum logic [1:0] {WARMUP, BASE, TRACK} state_t;

   logic [bit_width-1:0] r_sync [sync_stages];
   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [bit_width-1:0] r_prev_gray;
   logic [bit_width-1:0] r_prev_bin;
   logic                 r_locked;
   logic [bit_width-1:0] r_bin_out;
   logic                 r_step_valid;
   logic [bit_width-1:0] r_delta;
   logic                 r_multi_step;
   logic [acc_width-1:0] r_acc;
   logic                 r_acc_ovf;

   logic [bit_width-1:0] w_g_s;
   logic [bit_width-1:0] w_b_s;
   logic [bit_width-1:0] w_d;
   logic [bit_width-1:0] w_diff;
   logic                 w_multi;
   logic [SW-1:0]        w_sum;
   logic                 w_wrap;

   assign w_g_s = r_sync[sync_stages-1];

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      w_b_s = '0;
      for (int i = 0; i < bit_width; i++) begin
         w_b_s[i] = ^(w_g_s >> i);
      end
   end

   assign w_d    = w_b_s - r_prev_bin;
   assign w_diff = w_g_s ^ r_prev_gray;
   // More than one bit set <=> clearing the lowest set bit leaves something
   assign w_multi = (w_diff & (w_diff - ONE)) != '0;
   assign w_sum   = SW'(r_acc) + SW'(w_d);
   assign w_wrap  = |w_sum[SW-1:acc_width];

   // Input synchroniser: shifts every cycle regardless of tracking state
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < sync_stages; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= bus.gray_in;
         for (int i = 1; i < sync_stages; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // Warm-up / baseline / tracking state machine with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= WARMUP;
         r_cnt        <= '0;
         r_prev_gray  <= '0;
         r_prev_bin   <= '0;
         r_locked     <= 1'b0;
         r_bin_out    <= '0;
         r_step_valid <= 1'b0;
         r_delta      <= '0;
         r_multi_step <= 1'b0;
         r_acc        <= '0;
         r_acc_ovf    <= 1'b0;
      end else begin
         case (r_state)
            WARMUP: begin
               r_locked     <= 1'b0;
               r_step_valid <= 1'b0;
               r_delta      <= '0;
               r_multi_step <= 1'b0;
               if (!bus.enable) begin
                  r_cnt <= '0;
               end else if (r_cnt == LAST_CNT) begin
                  r_cnt   <= '0;
                  r_state <= BASE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            BASE: begin
               r_step_valid <= 1'b0;
               r_delta      <= '0;
               r_multi_step <= 1'b0;
               if (!bus.enable) begin
                  r_state <= WARMUP;
               end else begin
                  r_prev_gray <= w_g_s;
                  r_prev_bin  <= w_b_s;
                  r_bin_out   <= w_b_s;
                  r_locked    <= 1'b1;
                  r_state     <= TRACK;
               end
            end
            TRACK: begin
               if (!bus.enable) begin
                  r_state      <= WARMUP;
                  r_cnt        <= '0;
                  r_locked     <= 1'b0;
                  r_step_valid <= 1'b0;
                  r_delta      <= '0;
                  r_multi_step <= 1'b0;
               end else if (w_d != '0) begin
                  r_step_valid <= 1'b1;
                  r_delta      <= w_d;
                  r_multi_step <= w_multi;
                  r_bin_out    <= w_b_s;
                  r_prev_bin   <= w_b_s;
                  r_prev_gray  <= w_g_s;
                  r_acc        <= w_sum[acc_width-1:0];
                  if (w_wrap) r_acc_ovf <= 1'b1;
               end else begin
                  r_step_valid <= 1'b0;
                  r_delta      <= '0;
                  r_multi_step <= 1'b0;
               end
            end
            default: begin
               r_state <= WARMUP;
               r_cnt   <= '0;
            end
         endcase
         // Clear wins over any accumulation in the same cycle
         if (bus.clear) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
         end
      end
   end

   assign bus.locked       = r_locked;
   assign bus.bin_out      = r_bin_out;
   assign bus.step_valid   = r_step_valid;
   assign bus.delta        = r_delta;
   assign bus.multi_step   = r_multi_step;
   assign bus.acc_out      = r_acc;
   assign bus.acc_overflow = r_acc_ovf;
endmodule

// File: tb/tb_gray_ptr_receiver.sv
// tb/tb_gray_ptr_receiver.sv - directed self-checking bench for gray_ptr_receiver
module tb_gray_ptr_receiver;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   gray_ptr_receiver_if #(.bit_width(8), .acc_width(8)) bus ();

   gray_ptr_receiver #(.bit_width(8), .sync_stages(2), .acc_width(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.enable = 1'b0; bus.clear = 1'b0; bus.gray_in = 8'h00;
      tick(); tick();
      checks++;
      if ({bus.locked, bus.bin_out, bus.step_valid, bus.delta, bus.multi_step, bus.acc_out, bus.acc_overflow} !== 28'h0) begin
         errors++;
         $display("FAIL reset_outputs got locked=%0b bin=%0d sv=%0b delta=%0d ms=%0b acc=%0d ovf=%0b expected all 0",
                  bus.locked, bus.bin_out, bus.step_valid, bus.delta, bus.multi_step, bus.acc_out, bus.acc_overflow);
      end
   endtask

   task automatic test_lockup();
      rst = 1'b0; bus.enable = 1'b1; bus.gray_in = 8'h00;
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++;
         if (bus.locked !== (j == 2)) begin
            errors++; $display("FAIL lock_locked edge %0d got %0b expected %0b", j + 1, bus.locked, (j == 2));
         end
         checks++;
         if (bus.step_valid !== 1'b0) begin
            errors++; $display("FAIL lock_no_step edge %0d got %0b expected 0", j + 1, bus.step_valid);
         end
      end
      checks++;
      if (bus.bin_out !== 8'd0 || bus.acc_out !== 8'd0) begin
         errors++; $display("FAIL lock_values got bin=%0d acc=%0d expected bin=0 acc=0", bus.bin_out, bus.acc_out);
      end
   endtask

   task automatic test_counting();
      logic [7:0] seq [5] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
      int exp_bin;
      logic exp_sv;
      for (int j = 0; j < 8; j++) begin
         bus.gray_in = seq[(j < 5) ? j : 4];
         tick();
         exp_sv  = (j >= 2 && j <= 6);
         exp_bin = (j < 2) ? 0 : ((j > 6) ? 5 : j - 1);
         checks++;
         if (bus.step_valid !== exp_sv) begin
            errors++; $display("FAIL count_step j=%0d got %0b expected %0b", j, bus.step_valid, exp_sv);
         end
         checks++;
         if (bus.bin_out !== 8'(exp_bin) || bus.acc_out !== 8'(exp_bin)) begin
            errors++; $display("FAIL count_bin_acc j=%0d got bin=%0d acc=%0d expected %0d", j, bus.bin_out, bus.acc_out, exp_bin);
         end
         if (exp_sv) begin
            checks++;
            if (bus.delta !== 8'd1 || bus.multi_step !== 1'b0) begin
               errors++; $display("FAIL count_delta j=%0d got delta=%0d ms=%0b expected delta=1 ms=0", j, bus.delta, bus.multi_step);
            end
         end
      end
   endtask

   task automatic test_jump();
      bus.gray_in = 8'h0D;
      for (int j = 0; j < 5; j++) begin
         tick();
         checks++;
         if (bus.step_valid !== (j == 2)) begin
            errors++; $display("FAIL jump_step j=%0d got %0b expected %0b", j, bus.step_valid, (j == 2));
         end
         if (j == 2) begin
            checks++;
            if (bus.delta !== 8'd4 || bus.multi_step !== 1'b1) begin
               errors++; $display("FAIL jump_delta got delta=%0d ms=%0b expected delta=4 ms=1", bus.delta, bus.multi_step);
            end
         end
      end
      checks++;
      if (bus.bin_out !== 8'd9 || bus.acc_out !== 8'd9) begin
         errors++; $display("FAIL jump_values got bin=%0d acc=%0d expected bin=9 acc=9", bus.bin_out, bus.acc_out);
      end
   endtask

   task automatic test_disable();
      bus.enable = 1'b0;
      tick();
      checks++;
      if (bus.locked !== 1'b0) begin
         errors++; $display("FAIL dis_unlock got %0b expected 0", bus.locked);
      end
      bus.gray_in = 8'h1D;
      for (int j = 0; j < 4; j++) begin
         tick();
         checks++;
         if (bus.step_valid !== 1'b0 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL dis_quiet j=%0d got sv=%0b locked=%0b expected 0 0", j, bus.step_valid, bus.locked);
         end
      end
      checks++;
      if (bus.bin_out !== 8'd9) begin
         errors++; $display("FAIL dis_bin_hold got %0d expected 9", bus.bin_out);
      end
      bus.enable = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         checks++;
         if (bus.locked !== (j >= 2) || bus.step_valid !== 1'b0) begin
            errors++; $display("FAIL reacq j=%0d got locked=%0b sv=%0b expected locked=%0b sv=0", j, bus.locked, bus.step_valid, (j >= 2));
         end
      end
      checks++;
      if (bus.bin_out !== 8'd22 || bus.acc_out !== 8'd9) begin
         errors++; $display("FAIL reacq_values got bin=%0d acc=%0d expected bin=22 acc=9", bus.bin_out, bus.acc_out);
      end
   endtask

   task automatic test_reset_in_track();
      rst = 1'b1; bus.gray_in = 8'h81;
      tick();
      checks++;
      if ({bus.locked, bus.bin_out, bus.step_valid, bus.delta, bus.multi_step, bus.acc_out, bus.acc_overflow} !== 28'h0) begin
         errors++;
         $display("FAIL track_reset got locked=%0b bin=%0d acc=%0d expected all 0", bus.locked, bus.bin_out, bus.acc_out);
      end
      rst = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (bus.locked !== 1'b1 || bus.bin_out !== 8'd254 || bus.step_valid !== 1'b0 || bus.acc_out !== 8'd0) begin
         errors++; $display("FAIL relock_254 got locked=%0b bin=%0d sv=%0b acc=%0d expected 1 254 0 0",
                            bus.locked, bus.bin_out, bus.step_valid, bus.acc_out);
      end
   endtask

   task automatic test_wrap_overflow_clear();
      logic [7:0] g   [3] = '{8'h03, 8'h84, 8'h03};
      logic [7:0] d   [3] = '{8'd4, 8'd246, 8'd10};
      logic [7:0] b   [3] = '{8'd2, 8'd248, 8'd2};
      logic [7:0] a   [3] = '{8'd4, 8'd250, 8'd4};
      logic       o   [3] = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         bus.gray_in = g[k];
         tick(); tick();
         checks++;
         if (bus.step_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_early k=%0d got sv=%0b expected 0", k, bus.step_valid);
         end
         tick();
         checks++;
         if (bus.step_valid !== 1'b1 || bus.delta !== d[k] || bus.bin_out !== b[k]) begin
            errors++; $display("FAIL wrap_step k=%0d got sv=%0b delta=%0d bin=%0d expected 1 %0d %0d",
                               k, bus.step_valid, bus.delta, bus.bin_out, d[k], b[k]);
         end
         checks++;
         if (bus.acc_out !== a[k] || bus.acc_overflow !== o[k]) begin
            errors++; $display("FAIL wrap_acc k=%0d got acc=%0d ovf=%0b expected %0d %0b", k, bus.acc_out, bus.acc_overflow, a[k], o[k]);
         end
      end
      bus.gray_in = 8'h02;
      tick(); tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      checks++;
      if (bus.step_valid !== 1'b1 || bus.delta !== 8'd1 || bus.bin_out !== 8'd3) begin
         errors++; $display("FAIL clear_step got sv=%0b delta=%0d bin=%0d expected 1 1 3", bus.step_valid, bus.delta, bus.bin_out);
      end
      checks++;
      if (bus.acc_out !== 8'd0 || bus.acc_overflow !== 1'b0) begin
         errors++; $display("FAIL clear_acc got acc=%0d ovf=%0b expected 0 0", bus.acc_out, bus.acc_overflow);
      end
      tick();
      checks++;
      if (bus.step_valid !== 1'b0 || bus.acc_out !== 8'd0) begin
         errors++; $display("FAIL clear_after got sv=%0b acc=%0d expected 0 0", bus.step_valid, bus.acc_out);
      end
   endtask

   initial begin
      test_reset();
      test_lockup();
      test_counting();
      test_jump();
      test_disable();
      test_reset_in_track();
      test_wrap_overflow_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gray_ptr_receiver.md
Name: gray_ptr_receiver

Overview:
- Reader end of a Gray-coded pointer/counter interface. The input is a Gray-coded forward count produced in another timing domain.
- The block synchronises the input, decodes it to binary, detects advances and reports the step size. It also accumulates total advance and flags multi-step jumps.
- Sits at the consuming side of any Gray-coded pointer link, e.g. FIFO read-side occupancy or position tracking.

Parameters:
- bit_width, 8: width of the Gray input and the decoded binary pointer.
- sync_stages, 2: flip-flop stages in the input synchroniser; minimum 2.
- acc_width, 16: width of the advance accumulator.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  tracking enable; low forces re-acquisition.
- clear  input  1  synchronous clear of acc_out and acc_overflow.
- gray_in  input  bit_width  Gray-coded pointer; asynchronous to clk.
- locked  output  1  baseline captured, tracking active.
- bin_out  output  bit_width  last accepted pointer value, binary.
- step_valid  output  1  one-cycle pulse: pointer advanced this cycle.
- delta  output  bit_width  advance (new - prev) mod 2^bit_width; valid when step_valid=1, else 0.
- multi_step  output  1  with step_valid: more than one Gray bit changed since previous accepted sample.
- acc_out  output  acc_width  running sum of delta, wraps mod 2^acc_width.
- acc_overflow  output  1  sticky: acc_out wrapped at least once.

Behaviour:
- Reset (rst=1 at an edge):
  - Synchroniser chain, prev_gray and prev_bin are all 0.
  - Every output is 0.
  - State goes to WARMUP with the warmup counter at 0.
  - Reset overrides all other inputs.
- Synchroniser:
  - gray_in shifts through sync_stages flops every cycle, in every state. Only the last stage (g_s) is used.
  - g_s is decoded combinationally to b_s via MSB-first XOR prefix.
- State machine:
  - WARMUP:
    - If enable=0, stay in WARMUP with the counter at 0.
    - If enable=1, increment the counter. After sync_stages such cycles, go to BASE.
  - BASE (one cycle):
    - prev_gray<=g_s, prev_bin<=b_s, bin_out<=b_s, locked<=1. No step_valid.
    - Go to TRACK.
    - If enable=0 in this cycle, go to WARMUP instead and do not capture.
  - TRACK:
    - Compute d = b_s - prev_bin mod 2^bit_width.
    - If d != 0:
      - step_valid<=1, delta<=d, bin_out<=b_s, prev_bin<=b_s, prev_gray<=g_s.
      - multi_step<=(popcount(g_s ^ prev_gray) > 1).
      - acc_out<=acc_out + zero-extended d.
      - If the sum carries out, acc_out keeps the wrapped value and acc_overflow<=1.
    - If d == 0: step_valid<=0, delta<=0, multi_step<=0.
    - If enable=0: go to WARMUP, locked<=0, step_valid/delta/multi_step<=0.
      - bin_out, acc_out and acc_overflow hold.
      - Input changes while disabled are never reported.
- Latency: gray_in stable before edge k shows in bin_out/step_valid after edge k+sync_stages (3 cycles at default).
- Time to locked: after enable=1 with rst=0, locked rises after edge sync_stages+1.
- Wrap-around: delta is always modular, so pointer wrap (e.g. 254 -> 2) gives a positive delta.
- Backward movement is treated as a large forward delta; no backward flag.
- clear=1:
  - acc_out<=0 and acc_overflow<=0, taking priority over accumulation in the same cycle; that cycle's delta is not added.
  - step_valid, delta and bin_out behave normally.
- Re-acquisition after enable toggle: the new baseline replaces prev_bin without a step pulse; acc_out is unaffected.

Test Plan:
- Lock-up: rst 1->0, enable=1, gray_in=8'h00 held. Required: locked=1 after 3rd edge, bin_out=0, step_valid never pulses, acc_out=0.
- Counting: after lock, drive gray(1..5) (8'h01,03,02,06,07), one per cycle. Required:
  - Five consecutive step_valid pulses, each delta=1, multi_step=0.
  - bin_out 1..5, acc_out=5.
  - First pulse 3 cycles after 8'h01 is applied.
- Jump: from 8'h07 (bin 5), drive 8'h0D (bin 9) and hold. Required: single pulse, delta=4, multi_step=1, bin_out=9, acc_out=9.
- Wrap: lock on 8'h81 (bin 254), then drive 8'h03 (bin 2). Required: delta=4, bin_out=2, acc_out incremented by 4.
- Clear and overflow, with acc_width=8: accumulate to 250, then step delta=10. Required:
  - acc_out=4, acc_overflow=1.
  - clear asserted in the same cycle as the next delta=1 step: acc_out=0, acc_overflow=0, step_valid still pulses.
- Disable mid-stream: enable=0 at bin 9. Required:
  - locked=0 next edge.
  - Changing gray_in to 8'h1D (bin 22) gives no pulse.
  - After enable=1: locked after 3 edges, bin_out=22, no pulse, acc_out unchanged.
  - rst during TRACK returns all outputs to 0.
